// File: rtl/vip_csc_pkg.sv
// Shared constants and types for the RGB to YCbCr 4:4:4 colour-space converter.
package vip_csc_pkg;

    localparam int FRAC = 8;

    typedef enum logic [1:0] {
        CSC_601F = 2'd0,
        CSC_601L = 2'd1,
        CSC_709F = 2'd2,
        CSC_709L = 2'd3
    } csc_mode_e;

    typedef logic signed [8:0] coef_t;

    // Control fields that travel with every pipeline beat.
    typedef struct packed {
        logic valid;
        logic vsync;
        logic href;
        logic de;
    } side_t;

    // Per mode: Y(R,G,B), Cb(R,G,B), Cr(R,G,B), scaled by 2^FRAC.
    localparam coef_t CSC_COEF [4][9] = '{
        '{ 9'sd77,  9'sd150,  9'sd29, -9'sd43, -9'sd85, 9'sd128, 9'sd128, -9'sd107, -9'sd21},
        '{ 9'sd66,  9'sd129,  9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112, -9'sd94,  -9'sd18},
        '{ 9'sd54,  9'sd183,  9'sd19, -9'sd29, -9'sd99, 9'sd128, 9'sd128, -9'sd116, -9'sd12},
        '{ 9'sd47,  9'sd157,  9'sd16, -9'sd26, -9'sd86, 9'sd112, 9'sd112, -9'sd102, -9'sd10}
    };

    // Offsets and limited-range bounds are written for 8-bit video and
    // shifted left by (DW-8) where they are used.
    localparam logic [7:0] CSC_Y_OFS [4] = '{8'd0, 8'd16, 8'd0, 8'd16};
    localparam logic [7:0] CSC_C_OFS     = 8'd128;
    localparam logic [7:0] LIM_MIN       = 8'd16;
    localparam logic [7:0] LIM_Y_MAX     = 8'd235;
    localparam logic [7:0] LIM_C_MAX     = 8'd240;

    function automatic logic csc_is_limited(input csc_mode_e m);
        return (m == CSC_601L) || (m == CSC_709L);
    endfunction

endpackage

// File: rtl/vip_csc_mac3.sv
// One output channel: three products, offset/round sum, shift and clamp.
// Stages S1..S3 advance together on en; the caller supplies the offset
// for the beat entering S2 and the clamp bounds for the beat entering S3.
module vip_csc_mac3
    import vip_csc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] comp_r,
    input  logic [DW-1:0] comp_g,
    input  logic [DW-1:0] comp_b,
    input  coef_t         coef_r,
    input  coef_t         coef_g,
    input  coef_t         coef_b,
    input  logic [DW-1:0] offset,
    input  logic [DW-1:0] clamp_min,
    input  logic [DW-1:0] clamp_max,
    output logic [DW-1:0] result
);

    localparam int PW = DW + 9;
    localparam int SW = DW + 11;
    localparam logic signed [SW-1:0] ROUND = SW'(1 << (FRAC - 1));

    logic signed [PW-1:0] prod_r, prod_g, prod_b;
    logic signed [SW-1:0] sum_d, sum_q, shifted, lo, hi;
    logic        [DW-1:0] clamped;

    // Unsigned component times signed coefficient; the product always fits PW bits.
    function automatic logic signed [PW-1:0] mul(input logic [DW-1:0] c, input coef_t k);
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        a = $signed({9'd0, c});
        b = PW'(k);
        return a * b;
    endfunction

    // S1: register the three products.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
        end else if (en) begin
            prod_r <= mul(comp_r, coef_r);
            prod_g <= mul(comp_g, coef_g);
            prod_b <= mul(comp_b, coef_b);
        end
    end

    // Sum of products plus offset scaled by 2^FRAC plus the rounding half.
    always_comb begin
        sum_d = SW'(prod_r) + SW'(prod_g) + SW'(prod_b)
              + $signed({3'b000, offset, {FRAC{1'b0}}}) + ROUND;
    end

    // S2: register the rounded sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_d;
        end
    end

    // Drop the fraction and clamp into [clamp_min, clamp_max], both sides.
    // NOTE: clamped gets a default before the if-chain so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        shifted = sum_q >>> FRAC;
        lo      = $signed({11'd0, clamp_min});
        hi      = $signed({11'd0, clamp_max});
        clamped = shifted[DW-1:0];
        if (shifted < lo) begin
            clamped = clamp_min;
        end else if (shifted > hi) begin
            clamped = clamp_max;
        end
    end

    // S3: register the clamped channel value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (en) begin
            result <= clamped;
        end
    end

endmodule

// File: rtl/vip_rgb2ycbcr_csc.sv
// RGB to YCbCr 4:4:4 converter: 4-stage pipeline with valid/ready
// back-pressure, frame-aligned matrix switching and sideband delay.
module vip_rgb2ycbcr_csc
    import vip_csc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode_i,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_vsync,
    input  logic          in_href,
    input  logic          in_de,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_g,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_vsync,
    output logic          out_href,
    output logic          out_de,
    output logic [DW-1:0] out_y,
    output logic [DW-1:0] out_cb,
    output logic [DW-1:0] out_cr
);

    logic          en, accept, vs_rise, prev_vsync;
    csc_mode_e     mode_q, beat_mode, s1_mode, s2_mode;
    side_t         s1, s2, s3;
    coef_t         coef [9];
    logic [DW-1:0] y_ofs, c_ofs, y_min, y_max, c_min, c_max;
    logic [DW-1:0] y3, cb3, cr3;

    function automatic logic [DW-1:0] scale8(input logic [7:0] v);
        return DW'(v) << (DW - 8);
    endfunction

    // Whole pipeline advances unless the output holds a beat the sink refuses.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // A new frame (vsync rising in the accepted stream) takes mode_i at once.
    assign vs_rise   = in_vsync && !prev_vsync;
    assign beat_mode = vs_rise ? csc_mode_e'(mode_i) : mode_q;
    assign coef      = CSC_COEF[beat_mode];

    // Offset for the beat entering S2 and clamp bounds for the beat entering S3.
    always_comb begin
        y_ofs = scale8(CSC_Y_OFS[s1_mode]);
        c_ofs = scale8(CSC_C_OFS);
        if (csc_is_limited(s2_mode)) begin
            y_min = scale8(LIM_MIN);
            y_max = scale8(LIM_Y_MAX);
            c_min = scale8(LIM_MIN);
            c_max = scale8(LIM_C_MAX);
        end else begin
            y_min = '0;
            y_max = '1;
            c_min = '0;
            c_max = '1;
        end
    end

    // Track vsync of the accepted stream and latch the mode on its rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_vsync <= 1'b0;
            mode_q     <= CSC_601F;
        end else if (accept) begin
            prev_vsync <= in_vsync;
            if (vs_rise) begin
                mode_q <= csc_mode_e'(mode_i);
            end
        end
    end

    // Valid, sidebands and mode ride alongside the data; bubbles carry zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            s1_mode <= CSC_601F;
            s2_mode <= CSC_601F;
        end else if (en) begin
            s1      <= '{valid: in_valid,
                         vsync: in_valid & in_vsync,
                         href:  in_valid & in_href,
                         de:    in_valid & in_de};
            s1_mode <= beat_mode;
            s2      <= s1;
            s2_mode <= s1_mode;
            s3      <= s2;
        end
    end

    vip_csc_mac3 #(.DW(DW)) u_mac_y (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .comp_r    (in_r),
        .comp_g    (in_g),
        .comp_b    (in_b),
        .coef_r    (coef[0]),
        .coef_g    (coef[1]),
        .coef_b    (coef[2]),
        .offset    (y_ofs),
        .clamp_min (y_min),
        .clamp_max (y_max),
        .result    (y3)
    );

    vip_csc_mac3 #(.DW(DW)) u_mac_cb (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .comp_r    (in_r),
        .comp_g    (in_g),
        .comp_b    (in_b),
        .coef_r    (coef[3]),
        .coef_g    (coef[4]),
        .coef_b    (coef[5]),
        .offset    (c_ofs),
        .clamp_min (c_min),
        .clamp_max (c_max),
        .result    (cb3)
    );

    vip_csc_mac3 #(.DW(DW)) u_mac_cr (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .comp_r    (in_r),
        .comp_g    (in_g),
        .comp_b    (in_b),
        .coef_r    (coef[6]),
        .coef_g    (coef[7]),
        .coef_b    (coef[8]),
        .offset    (c_ofs),
        .clamp_min (c_min),
        .clamp_max (c_max),
        .result    (cr3)
    );

    // S4: output register; pixel data is blanked outside active lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_vsync <= 1'b0;
            out_href  <= 1'b0;
            out_de    <= 1'b0;
            out_y     <= '0;
            out_cb    <= '0;
            out_cr    <= '0;
        end else if (en) begin
            out_valid <= s3.valid;
            out_vsync <= s3.vsync;
            out_href  <= s3.href;
            out_de    <= s3.de;
            out_y     <= s3.href ? y3  : '0;
            out_cb    <= s3.href ? cb3 : '0;
            out_cr    <= s3.href ? cr3 : '0;
        end
    end

endmodule
